lcd_bus_rx: RTL and testbench

- Receiving end of the 8-bit HD44780-style character-LCD write bus (lcd_rs, lcd_rw, lcd_en, lcd_data) driven by the game's LCD writer.
- Decodes each lcd_en falling edge as one command or data transfer and keeps a 2x16 shadow of the visible DDRAM.
- Shadow has a read port plus status, so the game/debug logic can read back displayed text and check protocol sanity.

---
 rtl/lcd_bus_rx.sv | 189 ++++++++++++++++++
 tb/tb_lcd_bus_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_rx.sv
// Receiver for an 8-bit HD44780-style LCD write bus. It decodes each lcd_en fall and keeps a 2x16 DDRAM shadow.
// Optional macro LCD_EN_WIDTH_CHECK_EN discards enable pulses shorter than MIN_EN_CYCLES and flags err[3].
module lcd_bus_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_EN_CYCLES = 16
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       char_valid,
  output logic       frame_done,
  output logic [3:0] err
);

  if (SYNC_STAGES < 2 || MIN_EN_CYCLES < 1) begin : g_bad_param
    $error("lcd_bus_rx: SYNC_STAGES must be >= 2 and MIN_EN_CYCLES >= 1");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_nxt;
  logic [10:0] sync_q [SYNC_STAGES];
  logic        en_s, en_q, strobe;
  logic        hold_rs, hold_rw;
  logic [7:0]  hold_data;
  logic        width_ok, accept, clear_start;
  logic [4:0]  clr_idx;
  logic [7:0]  shadow [32];
  logic        inc_mode, cgram_mode;
  logic [2:0]  err_q;
  logic        on_screen;
  logic [4:0]  wr_idx;

  // The whole bus goes through the same synchroniser so that en and data stay aligned.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign en_s = sync_q[SYNC_STAGES-1][10];

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      hold_rs   <= 1'b0;
      hold_rw   <= 1'b0;
      hold_data <= '0;
    end else begin
      en_q <= en_s;
      if (en_s) {hold_rs, hold_rw, hold_data} <= sync_q[SYNC_STAGES-1][9:0];
    end
  end

  assign strobe = en_q & ~en_s;

`ifdef LCD_EN_WIDTH_CHECK_EN
  localparam int CNT_W = $clog2(MIN_EN_CYCLES + 1);
  logic [CNT_W-1:0] en_cnt;
  logic             err3_q;

  // The counter saturates at the threshold, so it never wraps on long pulses.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      en_cnt <= '0;
      err3_q <= 1'b0;
    end else begin
      if (!en_s)                                en_cnt <= '0;
      else if (en_cnt != CNT_W'(MIN_EN_CYCLES)) en_cnt <= en_cnt + 1'b1;
      if (strobe && !width_ok)                  err3_q <= 1'b1;
    end
  end

  assign width_ok = (en_cnt >= CNT_W'(MIN_EN_CYCLES));
  assign err      = {err3_q, err_q};
`else
  assign width_ok = 1'b1;
  assign err      = {1'b0, err_q};
`endif

  assign busy        = (state == CLEAR);
  assign accept      = strobe & width_ok & ~busy;
  assign clear_start = accept & ~hold_rw & ~hold_rs & (hold_data == 8'h01);

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= (state == CLEAR) ? clr_idx + 5'd1 : 5'd0;
    end
  end

  // NOTE: the next state gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_start) state_nxt = CLEAR;
      CLEAR:   if (clr_idx == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  // Line 1 is DDRAM 0x00-0x0F and line 2 is 0x40-0x4F. Bit 6 of the address selects the shadow half.
  assign on_screen = (cursor_addr[6:4] == 3'b000) || (cursor_addr[6:4] == 3'b100);
  assign wr_idx    = {cursor_addr[6], cursor_addr[3:0]};

  // NOTE: all sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      cursor_addr <= '0;
      inc_mode    <= 1'b1;
      cgram_mode  <= 1'b0;
      disp_on     <= 1'b0;
      cmd_code    <= '0;
      err_q       <= '0;
      cmd_valid   <= 1'b0;
      char_valid  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      char_valid <= 1'b0;
      frame_done <= 1'b0;
      if (strobe && width_ok && busy) err_q[2] <= 1'b1;
      if (accept) begin
        if (hold_rw) begin
          err_q[0] <= 1'b1;
        end else if (!hold_rs) begin
          cmd_valid <= 1'b1;
          cmd_code  <= hold_data;
          casez (hold_data)
            8'b1???????: begin cursor_addr <= hold_data[6:0]; cgram_mode <= 1'b0; end
            8'b01??????: cgram_mode <= 1'b1;
            8'b001?????: if (!hold_data[4]) err_q[1] <= 1'b1;
            8'b0001????: ;
            8'b00001???: disp_on <= hold_data[2];
            8'b000001??: inc_mode <= hold_data[1];
            8'b0000001?: cursor_addr <= '0;
            8'b00000001: begin
              cursor_addr <= '0;
              inc_mode    <= 1'b1;
              cgram_mode  <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          char_valid <= 1'b1;
          if (!cgram_mode) begin
            cursor_addr <= step_addr(cursor_addr, inc_mode);
            if (cursor_addr == 7'h4F) frame_done <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the shadow must read as blanks straight out of reset, so this small array resets to spaces.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
    end else if (busy) begin
      shadow[clr_idx] <= 8'h20;
    end else if (accept && !hold_rw && hold_rs && !cgram_mode && on_screen) begin
      shadow[wr_idx] <= hold_data;
    end
  end

  assign rd_data = shadow[rd_addr];

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Self-checking bench for lcd_bus_rx: a vector table and hand sequences, with a scoreboard on the pulse outputs.
`timescale 1ns/1ps
module tb_lcd_bus_rx;

  logic       clk_1MHz = 1'b0;
  logic       rst;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       disp_on, busy, cmd_valid, char_valid, frame_done;
  logic [7:0] cmd_code;
  logic [3:0] err;

  lcd_bus_rx dut (
    .clk_1MHz(clk_1MHz), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr),
    .disp_on(disp_on), .busy(busy), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .char_valid(char_valid), .frame_done(frame_done), .err(err)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  typedef struct {
    logic       is_cmd;
    logic [7:0] code;
    logic       frame;
  } ev_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         hi;
    logic [6:0] cur;
    logic       disp;
    logic [4:0] idx;
    logic [7:0] val;
  } vec_t;

  ev_t        sb_q[$];
  vec_t       tbl[18];
  logic [7:0] m_sh[32];
  logic [7:0] frame_txt[16];
  int n_chk = 0, n_pass = 0;
  int n_cmd = 0, n_char = 0, n_frame = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk_1MHz) begin
    if (frame_done) n_frame++;
    if (cmd_valid || char_valid) begin
      if (cmd_valid) n_cmd++;
      if (char_valid) n_char++;
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: cmd_valid=%0b char_valid=%0b, expected no pulse", cmd_valid, char_valid);
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        check("sb_kind", {cmd_valid, char_valid}, e.is_cmd ? 2'b10 : 2'b01);
        if (e.is_cmd) check("sb_code", cmd_code, e.code);
        check("sb_frame", frame_done, e.frame);
      end
    end else if (frame_done) begin
      n_chk++;
      $display("FAIL sb_frame_stray: frame_done=1, expected 0 without char_valid");
    end
  end

  task automatic push_ev(input logic is_cmd, input logic [7:0] code, input logic frame);
    ev_t e;
    e.is_cmd = is_cmd;
    e.code   = code;
    e.frame  = frame;
    sb_q.push_back(e);
  endtask

  task automatic xfer_raw(input logic rs, input logic rw, input logic [7:0] d, input int hi);
    @(negedge clk_1MHz);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (hi) @(negedge clk_1MHz);
    lcd_en = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    repeat (4) @(negedge clk_1MHz);
    while (busy && n < 200) begin
      @(negedge clk_1MHz);
      n++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL idle_timeout: busy=1 after 200 cycles, expected 0");
    end
  endtask

  task automatic cmd(input logic [7:0] d, input int hi = 20);
    push_ev(1'b1, d, 1'b0);
    xfer_raw(1'b0, 1'b0, d, hi);
    settle();
  endtask

  task automatic dat(input logic [7:0] d, input logic frame, input int hi = 20);
    push_ev(1'b0, d, frame);
    xfer_raw(1'b1, 1'b0, d, hi);
    settle();
  endtask

  task automatic rd_check(input string name, input int idx, input logic [7:0] exp);
    rd_addr = 5'(idx);
    #1;
    check(name, rd_data, exp);
  endtask

  initial begin
    string s;
    int busy_cnt, c0, ch0, f0;

    s = "      XOR       ";
    for (int i = 0; i < 16; i++) frame_txt[i] = s[i];

    tbl[0]  = '{rs:0, d:8'h0C, hi:500, cur:7'h00, disp:1, idx:0,  val:8'h20};
    tbl[1]  = '{rs:0, d:8'h38, hi:500, cur:7'h00, disp:1, idx:0,  val:8'h20};
    tbl[2]  = '{rs:0, d:8'h06, hi:500, cur:7'h00, disp:1, idx:0,  val:8'h20};
    tbl[3]  = '{rs:0, d:8'h80, hi:500, cur:7'h00, disp:1, idx:0,  val:8'h20};
    tbl[4]  = '{rs:1, d:8'h58, hi:500, cur:7'h01, disp:1, idx:0,  val:8'h58};
    tbl[5]  = '{rs:0, d:8'hC5, hi:20,  cur:7'h45, disp:1, idx:21, val:8'h20};
    tbl[6]  = '{rs:1, d:8'h42, hi:20,  cur:7'h46, disp:1, idx:21, val:8'h42};
    tbl[7]  = '{rs:0, d:8'h04, hi:20,  cur:7'h46, disp:1, idx:22, val:8'h20};
    tbl[8]  = '{rs:1, d:8'h43, hi:20,  cur:7'h45, disp:1, idx:22, val:8'h43};
    tbl[9]  = '{rs:0, d:8'h06, hi:20,  cur:7'h45, disp:1, idx:21, val:8'h42};
    tbl[10] = '{rs:0, d:8'h48, hi:20,  cur:7'h45, disp:1, idx:21, val:8'h42};
    tbl[11] = '{rs:1, d:8'h55, hi:20,  cur:7'h45, disp:1, idx:21, val:8'h42};
    tbl[12] = '{rs:0, d:8'h83, hi:20,  cur:7'h03, disp:1, idx:3,  val:8'h20};
    tbl[13] = '{rs:0, d:8'h10, hi:20,  cur:7'h03, disp:1, idx:3,  val:8'h20};
    tbl[14] = '{rs:0, d:8'h00, hi:20,  cur:7'h03, disp:1, idx:3,  val:8'h20};
    tbl[15] = '{rs:0, d:8'h08, hi:20,  cur:7'h03, disp:0, idx:0,  val:8'h58};
    tbl[16] = '{rs:0, d:8'h0D, hi:20,  cur:7'h03, disp:1, idx:0,  val:8'h58};
    tbl[17] = '{rs:0, d:8'h03, hi:20,  cur:7'h00, disp:1, idx:0,  val:8'h58};

    rst = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0; lcd_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk_1MHz);
    rst = 1'b0;
    @(negedge clk_1MHz);
    check("rst_cursor", cursor_addr, 7'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 4'h0);
    check("rst_disp", disp_on, 1'b0);
    rd_check("rst_shadow5", 5, 8'h20);

    // Init: the clear command must hold busy for exactly 32 cycles.
    c0 = n_cmd; ch0 = n_char;
    push_ev(1'b1, 8'h01, 1'b0);
    xfer_raw(1'b0, 1'b0, 8'h01, 500);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_1MHz);
      if (busy) busy_cnt++;
    end
    check("clear_busy_cycles", busy_cnt, 32);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rs) dat(tbl[i].d, 1'b0, tbl[i].hi);
      else           cmd(tbl[i].d, tbl[i].hi);
      check($sformatf("tbl%0d_cursor", i), cursor_addr, tbl[i].cur);
      check($sformatf("tbl%0d_disp", i), disp_on, tbl[i].disp);
      check($sformatf("tbl%0d_err", i), err, 4'h0);
      rd_check($sformatf("tbl%0d_shadow", i), tbl[i].idx, tbl[i].val);
      if (i == 4) begin
        check("init_cmd_pulses", n_cmd - c0, 5);
        check("init_char_pulses", n_char - ch0, 1);
      end
    end

    // Full frame: line 1 carries the text and line 2 is blank. Only the 0x4F write may raise frame_done.
    f0 = n_frame;
    for (int p = 0; p < 16; p++) begin
      cmd(8'h80 | 8'(p));
      dat(frame_txt[p], 1'b0);
      cmd(8'hC0 | 8'(p));
      dat(8'h20, p == 15);
    end
    for (int i = 0; i < 16; i++) begin
      m_sh[i] = frame_txt[i];
      m_sh[16+i] = 8'h20;
    end
    for (int i = 0; i < 32; i++) rd_check($sformatf("frame_sh%0d", i), i, m_sh[i]);
    check("frame_done_count", n_frame - f0, 1);

    // Wrap: a write at 0x27 is off-screen and then steps the cursor to 0x40. A decrement from 0 wraps to 0x67.
    cmd(8'hA7);
    dat(8'h41, 1'b0);
    check("wrap_inc_cursor", cursor_addr, 7'h40);
    for (int i = 0; i < 32; i++) rd_check($sformatf("wrap_sh%0d", i), i, m_sh[i]);
    cmd(8'h04);
    cmd(8'h80);
    dat(8'h42, 1'b0);
    m_sh[0] = 8'h42;
    check("wrap_dec_cursor", cursor_addr, 7'h67);
    rd_check("wrap_dec_sh0", 0, 8'h42);
    cmd(8'h06);

    // Errors: a read strobe, a 4-bit function set, and a strobe while the clear is in progress.
    cmd(8'h80);
    xfer_raw(1'b1, 1'b1, 8'h77, 20);
    settle();
    check("rw_err", err, 4'h1);
    check("rw_cursor", cursor_addr, 7'h00);
    rd_check("rw_sh0", 0, 8'h42);
    cmd(8'h28);
    check("fset_err", err, 4'h3);
    push_ev(1'b1, 8'h01, 1'b0);
    xfer_raw(1'b0, 1'b0, 8'h01, 20);
    xfer_raw(1'b1, 1'b0, 8'h41, 20);
    settle();
    check("busy_drop_err", err, 4'h7);
    check("busy_drop_cursor", cursor_addr, 7'h00);
    rd_check("busy_drop_sh0", 0, 8'h20);
    rd_check("busy_drop_sh31", 31, 8'h20);

    // Glitch: the enable is high for only 4 cycles.
`ifdef LCD_EN_WIDTH_CHECK_EN
    xfer_raw(1'b1, 1'b0, 8'h41, 4);
    settle();
    check("glitch_err", err, 4'hF);
    check("glitch_cursor", cursor_addr, 7'h00);
    rd_check("glitch_sh0", 0, 8'h20);
`else
    dat(8'h41, 1'b0, 4);
    check("glitch_err", err, 4'h7);
    check("glitch_cursor", cursor_addr, 7'h01);
    rd_check("glitch_sh0", 0, 8'h41);
`endif

    // Reset during a clear: entry 31 holds a character that the clear has not reached yet.
    cmd(8'hCF);
    dat(8'h41, 1'b1);
    rd_check("pre_rst_sh31", 31, 8'h41);
    push_ev(1'b1, 8'h01, 1'b0);
    xfer_raw(1'b0, 1'b0, 8'h01, 20);
    repeat (8) @(negedge clk_1MHz);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk_1MHz);
    rst = 1'b0;
    @(negedge clk_1MHz);
    for (int i = 0; i < 32; i++) rd_check($sformatf("rst_sh%0d", i), i, 8'h20);
    check("rst2_cursor", cursor_addr, 7'h00);
    check("rst2_busy", busy, 1'b0);
    check("rst2_err", err, 4'h0);
    check("rst2_disp", disp_on, 1'b0);
    check("rst2_cmd_code", cmd_code, 8'h00);
    repeat (50) @(negedge clk_1MHz);
    check("rst2_busy_late", busy, 1'b0);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
